// File: rtl/bram_pkg.sv
// Shared constants for the BRAM controller slice and its read-return buffer.
package bram_pkg;

    localparam int unsigned BRAM_DW         = 32;
    localparam int unsigned BRAM_AW         = 13;
    localparam int unsigned BRAM_LAT        = 10;
    localparam int unsigned BRAM_FIFO_DEPTH = 16;
    localparam int unsigned BRAM_MAX_OUT    = 15;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, asynchronous read at rd_ptr.
module sync_fifo_mem #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_ptr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_ptr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/bram_rd_fifo.sv
// Read-return buffer behind the BRAM controller: FWFT FIFO with read-credit
// generation for the arbiter and flush of buffered and in-flight returns.
module bram_rd_fifo
    import bram_pkg::*;
#(
    parameter int unsigned DW      = BRAM_DW,
    parameter int unsigned DEPTH   = BRAM_FIFO_DEPTH,
    parameter int unsigned MAX_OUT = BRAM_MAX_OUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_issue,
    input  logic          fifo_in_valid,
    input  logic [DW-1:0] fifo_in_data,
    input  logic          flush,
    output logic          rd_credit,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          ovf_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);
    localparam logic [CW:0]   MAX_L   = (CW + 1)'(MAX_OUT);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] keep_cnt;
    logic [CW-1:0] drop_cnt;
    logic          ovf_q;

    logic [DW-1:0] mem_rd_data;
    logic          pop;
    logic          full;
    logic          has_drop;
    logic          has_keep;
    logic          take_drop;
    logic          take_keep;
    logic          ret;
    logic          push;
    logic          err_orphan;
    logic          err_full;
    logic [CW:0]   sum_ck;
    logic [CW:0]   sum_kd;

    sync_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push & ~flush & ~rst),
        .wr_ptr  (wr_ptr),
        .wr_data (fifo_in_data),
        .rd_ptr  (rd_ptr),
        .rd_data (mem_rd_data)
    );

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem_rd_data : '0;
    assign ovf_err   = ovf_q;

    // Returns arrive in issue order, so pending discards are always the oldest beats.
    always_comb begin
        pop        = out_valid & out_ready;
        full       = (count == DEPTH_C);
        has_drop   = (drop_cnt != '0);
        has_keep   = (keep_cnt != '0);
        take_drop  = fifo_in_valid & has_drop;
        take_keep  = fifo_in_valid & ~has_drop & has_keep;
        ret        = take_drop | take_keep;
        push       = take_keep & (~full | pop);
        err_orphan = fifo_in_valid & ~has_drop & ~has_keep;
        err_full   = take_keep & full & ~pop;
        sum_ck     = {1'b0, count} + {1'b0, keep_cnt};
        sum_kd     = {1'b0, keep_cnt} + {1'b0, drop_cnt};
        rd_credit  = (sum_ck < DEPTH_L) && (sum_kd < MAX_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            keep_cnt <= '0;
            drop_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (flush) begin
            // Everything kept so far, plus a same-cycle issue, becomes a discard;
            // a beat returning this cycle retires the oldest of them.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            keep_cnt <= '0;
            drop_cnt <= drop_cnt + keep_cnt + CW'(rd_issue) - CW'(ret);
            ovf_q    <= ovf_q | err_orphan;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count + CW'(push) - CW'(pop);
            keep_cnt <= keep_cnt + CW'(rd_issue) - CW'(take_keep);
            drop_cnt <= drop_cnt - CW'(take_drop);
            ovf_q    <= ovf_q | err_orphan | err_full;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (sum_kd <= MAX_L);
            assert (count <= DEPTH_C);
        end
    end

endmodule

// File: tb/tb_bram_rd_fifo.sv
// Directed bench for bram_rd_fifo with a queue scoreboard checked by a pop monitor.
module tb_bram_rd_fifo;
    import bram_pkg::*;

    localparam int unsigned DW = BRAM_DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_issue;
    logic          fifo_in_valid;
    logic [DW-1:0] fifo_in_data;
    logic          flush;
    logic          rd_credit;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          ovf_err;

    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_exp;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    bram_rd_fifo #(
        .DW      (DW),
        .DEPTH   (16),
        .MAX_OUT (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_issue      (rd_issue),
        .fifo_in_valid (fifo_in_valid),
        .fifo_in_data  (fifo_in_data),
        .flush         (flush),
        .rd_credit     (rd_credit),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .ovf_err       (ovf_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input bit expect_store);
        fifo_in_valid = 1'b1;
        fifo_in_data  = d;
        if (expect_store) exp_q.push_back(d);
        step();
        fifo_in_valid = 1'b0;
        fifo_in_data  = '0;
    endtask

    task automatic issue();
        rd_issue = 1'b1;
        step();
        rd_issue = 1'b0;
    endtask

    // Monitor: every accepted pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!out_valid) begin
                check("out_data_zero_idle", out_data, 0);
            end else if (out_ready && !flush && !rst) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pop: got 0x%0h expected no data", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("pop_data", out_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #300000;
        miscompares++;
        $display("FAIL global_timeout: got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        logic [9:0] pipe;
        int unsigned issued;
        int unsigned returned;

        rst = 1'b1; rd_issue = 1'b0; fifo_in_valid = 1'b0; fifo_in_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_rd_credit", rd_credit, 1);
        check("rst_ovf_err", ovf_err, 0);
        check("rst_keep_cnt", dut.keep_cnt, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single read with controller latency
        issue();
        check("single_keep_after_issue", dut.keep_cnt, 1);
        repeat (9) step();
        out_ready = 1'b1;
        beat(32'hDEADBEEF, 1'b1);
        check("single_valid_after_beat", out_valid, 1);
        check("single_keep_back_zero", dut.keep_cnt, 0);
        step();
        check("single_valid_one_cycle", out_valid, 0);
        check("single_ovf", ovf_err, 0);

        // Fill to both credit bounds, then push+pop on a full FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("fill_credit_before_issue", rd_credit, 1);
            issue();
        end
        check("credit_max_out_bound", rd_credit, 0);
        for (int i = 0; i < 15; i++) beat(DW'(i), 1'b1);
        check("credit_after_returns", rd_credit, 1);
        issue();
        check("credit_depth_bound", rd_credit, 0);
        beat(DW'(15), 1'b1);
        check("full_count", dut.count, 16);
        check("full_credit", rd_credit, 0);
        issue();
        out_ready = 1'b1;
        beat(DW'(16), 1'b1);
        out_ready = 1'b0;
        check("push_pop_full_count", dut.count, 16);
        check("push_pop_full_ovf", ovf_err, 0);
        check("push_pop_full_keep", dut.keep_cnt, 0);
        check("full_credit_no_pop", rd_credit, 0);
        out_ready = 1'b1;
        step();
        check("credit_after_one_pop", rd_credit, 1);
        for (int i = 0; i < 40 && out_valid; i++) step();
        check("drain_empty", out_valid, 0);
        check("drain_scoreboard_empty", exp_q.size(), 0);

        // Flush with reads in flight
        for (int i = 0; i < 4; i++) issue();
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_drop_cnt", dut.drop_cnt, 4);
        check("flush_keep_cnt", dut.keep_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            beat(32'hBAD00000 + DW'(i), 1'b0);
            check("flush_no_store", out_valid, 0);
        end
        check("flush_drop_zero", dut.drop_cnt, 0);
        check("flush_ovf", ovf_err, 0);

        // Flush coinciding with an issue and a returning beat
        issue();
        issue();
        rd_issue = 1'b1; flush = 1'b1;
        beat(32'hBAD1BAD1, 1'b0);
        rd_issue = 1'b0; flush = 1'b0;
        check("flush_same_cycle_drop", dut.drop_cnt, 2);
        check("flush_same_cycle_keep", dut.keep_cnt, 0);
        check("flush_same_cycle_count", dut.count, 0);
        beat(32'hBAD2BAD2, 1'b0);
        beat(32'hBAD3BAD3, 1'b0);
        check("flush_same_cycle_drained", dut.drop_cnt, 0);
        check("flush_same_cycle_empty", out_valid, 0);
        issue();
        repeat (3) step();
        beat(32'h12345678, 1'b1);
        check("fresh_read_valid", out_valid, 1);
        step();
        check("fresh_read_popped", out_valid, 0);
        check("fresh_read_ovf", ovf_err, 0);

        // Streaming across pointer wrap, returns 10 cycles after issue
        pipe = '0; issued = 0; returned = 0;
        for (int c = 0; c < 120 && returned < 40; c++) begin
            rd_issue      = (issued < 40) && rd_credit;
            fifo_in_valid = pipe[9];
            fifo_in_data  = '0;
            if (pipe[9]) begin
                fifo_in_data = DW'(returned);
                exp_q.push_back(DW'(returned));
                returned++;
            end
            pipe = {pipe[8:0], rd_issue};
            if (rd_issue) issued++;
            step();
        end
        rd_issue = 1'b0; fifo_in_valid = 1'b0; fifo_in_data = '0;
        for (int i = 0; i < 20 && out_valid; i++) step();
        check("stream_all_returned", returned, 40);
        check("stream_scoreboard_empty", exp_q.size(), 0);
        check("stream_ovf", ovf_err, 0);

        // Beat with no outstanding read
        beat(32'hBAD4BAD4, 1'b0);
        check("orphan_ovf_set", ovf_err, 1);
        check("orphan_not_stored", out_valid, 0);
        repeat (5) step();
        check("orphan_ovf_sticky", ovf_err, 1);
        rst = 1'b1;
        step();
        check("rst_clears_ovf", ovf_err, 0);
        check("rst_credit", rd_credit, 1);
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
